countdown_timer: RTL and testbench

- Down-counting companion to the up `counter` block.
- Loads a start value, decrements by a programmable step while `en` is high, and reports expiry.
- Optionally auto-reloads the last loaded value on expiry.
- Sits next to `counter` in timeout and interval logic; `val` and `non_zero` keep the same meaning as on `counter`.

---
 rtl/counter_pkg.sv | 13 +
 rtl/countdown_step.sv | 23 ++
 rtl/countdown_timer.sv | 82 ++++++++
 tb/tb_countdown_timer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Types and constants shared by the up counter and the countdown timer.
package counter_pkg;

   localparam int unsigned WIDTH_DEF = 4;

   // 2'd3 is unreachable; the timer recovers from it to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/countdown_step.sv
// Saturating subtract of one decrement step, with an underflow (expiry) flag.
module countdown_step
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH_P = WIDTH_DEF
) (
   input  logic [WIDTH_P-1:0] val_i,
   input  logic [WIDTH_P-1:0] dec_i,
   output logic [WIDTH_P-1:0] next_val_o,
   output logic               underflow_o
);

   // Compare before subtracting so the result never wraps.
   always_comb begin
      next_val_o  = '0;
      underflow_o = 1'b0;
      if (val_i > dec_i) begin
         next_val_o = val_i - dec_i;
      end
      underflow_o = (val_i <= dec_i) && (dec_i != '0);
   end

endmodule

// File: rtl/countdown_timer.sv
// Down counter with programmable step, expiry pulse and optional auto-reload.
module countdown_timer
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH_P = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [WIDTH_P-1:0] load_val,
   input  logic [WIDTH_P-1:0] dec,
   input  logic               en,
   input  logic               clr,
   input  logic               auto_reload,
   output logic [WIDTH_P-1:0] val,
   output logic               non_zero,
   output logic               busy,
   output logic               expired
);

   logic [WIDTH_P-1:0] val_q;
   logic [WIDTH_P-1:0] reload_q;
   state_e             state_q;
   logic               expired_q;

   logic [WIDTH_P-1:0] val_d;
   logic               underflow;

   countdown_step #(
      .WIDTH_P (WIDTH_P)
   ) u_step (
      .val_i       (val_q),
      .dec_i       (dec),
      .next_val_o  (val_d),
      .underflow_o (underflow)
   );

   // Priority per edge: reset > clr > load > decrement.
   always_ff @(posedge clk) begin
      if (reset) begin
         val_q     <= '0;
         reload_q  <= '0;
         state_q   <= IDLE;
         expired_q <= 1'b0;
      end else if (clr) begin
         val_q     <= '0;
         state_q   <= IDLE;
         expired_q <= 1'b0;
      end else if (load) begin
         val_q     <= load_val;
         reload_q  <= load_val;
         state_q   <= (load_val != '0) ? RUN : IDLE;
         expired_q <= 1'b0;
      end else begin
         expired_q <= 1'b0;
         case (state_q)
            IDLE: ;
            RUN: begin
               if (en && underflow) begin
                  expired_q <= 1'b1;
                  if (auto_reload) begin
                     val_q <= reload_q;
                  end else begin
                     val_q   <= '0;
                     state_q <= DONE;
                  end
               end else if (en) begin
                  val_q <= val_d;
               end
            end
            DONE: val_q <= '0;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign val      = val_q;
   assign non_zero = (val_q != '0);
   assign busy     = (state_q == RUN);
   assign expired  = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table plus scoreboarded sequences.
module tb_countdown_timer;

   localparam int unsigned W = 4;

   typedef struct {
      logic         rst;
      logic         ld;
      logic [W-1:0] lv;
      logic [W-1:0] dc;
      logic         en;
      logic         clr;
      logic         ar;
      logic [W-1:0] e_val;
      logic         e_nz;
      logic         e_busy;
      logic         e_exp;
   } vec_t;

   typedef struct {
      logic [W-1:0] val;
      logic         nz;
      logic         busy;
      logic         exp;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset, load, en, clr, auto_reload;
   logic [W-1:0] load_val, dec;
   logic [W-1:0] val;
   logic         non_zero, busy, expired;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t vecs[$];

   countdown_timer #(.WIDTH_P(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .load_val    (load_val),
      .dec         (dec),
      .en          (en),
      .clr         (clr),
      .auto_reload (auto_reload),
      .val         (val),
      .non_zero    (non_zero),
      .busy        (busy),
      .expired     (expired)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   function automatic vec_t v(input logic r, input logic l, input int lv, input int dc,
                              input logic e, input logic c, input logic a,
                              input int ev, input logic enz, input logic eb, input logic ee);
      vec_t t;
      t.rst = r; t.ld = l; t.lv = W'(lv); t.dc = W'(dc); t.en = e; t.clr = c; t.ar = a;
      t.e_val = W'(ev); t.e_nz = enz; t.e_busy = eb; t.e_exp = ee;
      return t;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive one edge's inputs, queue the expectation, compare after the edge.
   task automatic step(input vec_t t);
      exp_t e;
      @(negedge clk);
      reset = t.rst; load = t.ld; load_val = t.lv; dec = t.dc;
      en = t.en; clr = t.clr; auto_reload = t.ar;
      e.val = t.e_val; e.nz = t.e_nz; e.busy = t.e_busy; e.exp = t.e_exp;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: got empty queue, required an entry");
      end else begin
         e = sb.pop_front();
         check("val", int'(val), int'(e.val));
         check("non_zero", int'(non_zero), int'(e.nz));
         check("busy", int'(busy), int'(e.busy));
         check("expired", int'(expired), int'(e.exp));
      end
   endtask

   initial begin
      int mv;
      logic mrun, mexp, en_b;
      reset = 1'b1; load = 1'b0; load_val = '0; dec = '0;
      en = 1'b0; clr = 1'b0; auto_reload = 1'b0;

      //                rst ld lv dc en clr ar   val nz b  e
      // reset dominates load
      vecs.push_back(v(1, 1, 9, 0, 0, 0, 0,   0, 0, 0, 0));
      vecs.push_back(v(1, 1, 9, 0, 0, 0, 0,   0, 0, 0, 0));
      // basic countdown, load edge does not decrement
      vecs.push_back(v(0, 1, 5, 1, 1, 0, 0,   5, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   4, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   3, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   2, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   1, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 1,   0, 0, 0, 0));
      // saturation: 7,4,1,0 never wraps
      vecs.push_back(v(0, 1, 7, 3, 1, 0, 0,   7, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 3, 1, 0, 0,   4, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 3, 1, 0, 0,   1, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 0));
      // dec=0 holds
      vecs.push_back(v(0, 1, 7, 0, 1, 0, 0,   7, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 0,   7, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 0,   7, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 0,   7, 1, 1, 0));
      // en=0 in RUN holds
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,   7, 1, 1, 0));
      // auto-reload 3,2,1,3,...
      vecs.push_back(v(0, 1, 3, 1, 1, 0, 1,   3, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 1,   2, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 1,   1, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 1,   3, 1, 1, 1));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 1,   2, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 1,   1, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 1,   3, 1, 1, 1));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   2, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   1, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 1));
      // back-to-back reloads pulse on consecutive cycles
      vecs.push_back(v(0, 1, 2, 2, 1, 0, 1,   2, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 2, 1, 0, 1,   2, 1, 1, 1));
      vecs.push_back(v(0, 0, 0, 2, 1, 0, 1,   2, 1, 1, 1));
      // priority: clr beats load; load edge does not decrement
      vecs.push_back(v(0, 1, 9, 3, 1, 0, 0,   9, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 3, 1, 0, 0,   6, 1, 1, 0));
      vecs.push_back(v(0, 1, 9, 3, 1, 1, 0,   0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0));
      vecs.push_back(v(0, 1, 9, 1, 1, 0, 0,   9, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   8, 1, 1, 0));
      vecs.push_back(v(0, 1, 0, 1, 1, 0, 0,   0, 0, 0, 0));
      // clr on what would be the expiry edge suppresses the pulse
      vecs.push_back(v(0, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 1, 0,   0, 0, 0, 0));
      // DONE is left by load
      vecs.push_back(v(0, 1, 1, 1, 1, 0, 0,   1, 1, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 1));
      vecs.push_back(v(0, 1, 4, 1, 1, 0, 0,   4, 1, 1, 0));

      foreach (vecs[i]) step(vecs[i]);

      // Enable gating: 10 edges on, 10 off; expiry after the 15th enabled edge.
      step(v(0, 1, 15, 1, 0, 0, 0, 15, 1, 1, 0));
      mv = 15; mrun = 1'b1;
      for (int i = 0; i < 40; i++) begin
         en_b = ((i / 10) % 2) == 0;
         mexp = 1'b0;
         if (mrun && en_b) begin
            if (mv <= 1) begin
               mv = 0; mrun = 1'b0; mexp = 1'b1;
            end else begin
               mv = mv - 1;
            end
         end
         step(v(0, 0, 0, 1, en_b, 0, 0, mv, mv != 0, mrun, mexp));
      end

      // Repeat, then reset at val=8 with en still high.
      step(v(0, 1, 15, 1, 0, 0, 0, 15, 1, 1, 0));
      for (int i = 14; i >= 8; i--) step(v(0, 0, 0, 1, 1, 0, 0, i, 1, 1, 0));
      step(v(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
      step(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
